// File: rtl/ov7670_capture_rgb888.sv
// OV7670 RGB565 capture: pairs camera bytes into RGB888 pixels and queues them for the display.
// Build option CAM_TEST_PATTERN_EN adds a test_mode input that substitutes 8 vertical colour bars.
module ov7670_capture_rgb888 #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int H_PIXELS    = 320,
  parameter int V_LINES     = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_pclk,
  input  logic        cam_href,
  input  logic        cam_vsync,
  input  logic [7:0]  cam_d,
`ifdef CAM_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic        colour_load_comp,
  output logic        colour_ready,
  output logic [23:0] colour_data,
  output logic        VS,
  output logic        overflow,
  output logic        frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE0, BYTE1} state_t;

  logic [SYNC_STAGES-1:0] pclk_s, href_s, vsync_s;
  logic [7:0]             d_s [SYNC_STAGES];
  logic                   pclk_q, href_q, vs_q, load_q;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_s  <= '0;
      href_s  <= '0;
      vsync_s <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) d_s[i] <= '0;
      pclk_q  <= 1'b0;
      href_q  <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      pclk_s  <= {pclk_s[SYNC_STAGES-2:0], cam_pclk};
      href_s  <= {href_s[SYNC_STAGES-2:0], cam_href};
      vsync_s <= {vsync_s[SYNC_STAGES-2:0], cam_vsync};
      d_s[0]  <= cam_d;
      for (int i = 1; i < SYNC_STAGES; i++) d_s[i] <= d_s[i-1];
      pclk_q  <= pclk_s[SYNC_STAGES-1];
      href_q  <= href_s[SYNC_STAGES-1];
      vs_q    <= vsync_s[SYNC_STAGES-1];
    end
  end

  logic       pclk_edge, href, href_fall, vs, vs_rise, vs_fall;
  logic [7:0] d;

  assign pclk_edge = pclk_s[SYNC_STAGES-1] & ~pclk_q;
  assign href      = href_s[SYNC_STAGES-1];
  assign href_fall = href_q & ~href;
  assign d         = d_s[SYNC_STAGES-1];
  assign vs        = vsync_s[SYNC_STAGES-1];
  assign vs_rise   = vs & ~vs_q;
  assign vs_fall   = ~vs & vs_q;
  assign VS        = vs;

  state_t state, state_next;
  logic   cap_byte0, push_req, line_end, frame_start, frame_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_FRAME;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next  = state;
    cap_byte0   = 1'b0;
    push_req    = 1'b0;
    line_end    = 1'b0;
    frame_start = 1'b0;
    frame_end   = vs_rise;
    if (vs) begin
      state_next = WAIT_FRAME;
    end else begin
      unique case (state)
        WAIT_FRAME: if (vs_fall) begin
          frame_start = 1'b1;
          state_next  = WAIT_LINE;
        end
        WAIT_LINE: if (pclk_edge && href) begin
          cap_byte0  = 1'b1;
          state_next = BYTE1;
        end
        BYTE0: if (href_fall) begin
          line_end   = 1'b1;
          state_next = WAIT_LINE;
        end else if (pclk_edge && href) begin
          cap_byte0  = 1'b1;
          state_next = BYTE1;
        end
        BYTE1: if (href_fall) begin
          line_end   = 1'b1;
          state_next = WAIT_LINE;
        end else if (pclk_edge && href) begin
          push_req   = 1'b1;
          state_next = BYTE0;
        end
        default: state_next = WAIT_FRAME;
      endcase
    end
  end

  logic [7:0] byte0_q;
  logic [9:0] pix_cnt, line_cnt;
  logic       line_bad;

  logic [AW:0]  wr_ptr, rd_ptr, wr_next, rd_next;
  logic         empty, full, pop, do_push, drop, ready_next;
  logic [23:0]  pixel, cam_pixel, head_next;
  logic [23:0]  mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte0_q   <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      line_bad  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cap_byte0) byte0_q <= d;
      if (state == WAIT_LINE)                 pix_cnt <= '0;
      else if (push_req && pix_cnt != 10'h3FF) pix_cnt <= pix_cnt + 10'd1;
      if (frame_start) begin
        line_cnt <= '0;
        line_bad <= 1'b0;
      end else if (line_end) begin
        if (line_cnt != 10'h3FF)       line_cnt <= line_cnt + 10'd1;
        if (pix_cnt != 10'(H_PIXELS))  line_bad <= 1'b1;
      end
      if (frame_end)   frame_err <= (line_cnt != 10'(V_LINES)) || line_bad;
      if (frame_start) overflow  <= 1'b0;
      else if (drop)   overflow  <= 1'b1;
    end
  end

  // RGB565 split across the byte pair, widened by replicating each channel's MSBs.
  logic [4:0] r5, b5;
  logic [5:0] g6;
  assign r5        = byte0_q[7:3];
  assign g6        = {byte0_q[2:0], d[7:5]};
  assign b5        = d[4:0];
  assign cam_pixel = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

`ifdef CAM_TEST_PATTERN_EN
  localparam int BAR_W = (H_PIXELS >= 8) ? H_PIXELS / 8 : 1;
  logic [9:0] bar_full;
  logic [2:0] bar;
  assign bar_full = pix_cnt / 10'(BAR_W);
  assign bar      = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];
  // Bar order white..black falls out of inverting the index bits per channel.
  assign pixel    = test_mode ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : cam_pixel;
`else
  assign pixel    = cam_pixel;
`endif

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = colour_load_comp & ~load_q & ~empty & ~vs;
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_comb begin
    wr_next    = wr_ptr + {{AW{1'b0}}, do_push};
    rd_next    = vs ? wr_ptr : rd_ptr + {{AW{1'b0}}, pop};
    ready_next = (wr_next != rd_next);
    // A pixel written this cycle into the slot that becomes head must bypass the array.
    if (do_push && rd_next[AW-1:0] == wr_ptr[AW-1:0]) head_next = pixel;
    else                                              head_next = mem[rd_next[AW-1:0]];
  end

  // NOTE: the pixel array is left unreset; pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= pixel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      load_q       <= 1'b0;
      colour_ready <= 1'b0;
      colour_data  <= '0;
    end else begin
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      load_q       <= colour_load_comp;
      colour_ready <= ready_next;
      if (ready_next) colour_data <= head_next;
    end
  end
endmodule
